// File: rtl/host_bus_interface.sv
`default_nettype none
// ============================================================================
// Module   : host_bus_interface
// Purpose  : Synchronous front end for an asynchronous, DTACK-style host bus.
//            The host strobes are brought into the clock domain through
//            two-flop synchronisers. Each accepted host write becomes a
//            single-cycle reg_wr_strobe with stable address/data. Each host
//            read is served from the packed register contents and pulses
//            reg_rd_strobe. The host is acknowledged with host_ack_n.
// Ports    :
//   clock          in   system clock, rising-edge active
//   reset_n        in   asynchronous active-low reset
//   host_cs_n      in   host chip select (async, active low)
//   host_wr_n      in   host write strobe (async, active low)
//   host_rd_n      in   host read strobe (async, active low)
//   host_address   in   host address, stable while host_cs_n low
//   host_data_in   in   host write data, stable while host_cs_n low
//   host_data_out  out  read data to host
//   host_data_oe   out  drive enable for host_data_out
//   host_ack_n     out  cycle acknowledge, active low
//   host_error     out  sticky protocol error (cleared by reset only)
//   reg_address    out  latched register address
//   reg_data       out  latched write data
//   reg_wr_strobe  out  one-cycle write pulse
//   reg_rd_strobe  out  one-cycle read pulse
//   rd_data        in   packed register contents, reg i at [i*WIDTH +: WIDTH]
// Revision : 1.0  initial release
// ============================================================================
module host_bus_interface #(
   parameter int COUNT = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       host_cs_n,
   input  logic                       host_wr_n,
   input  logic                       host_rd_n,
   input  logic [$clog2(COUNT)-1:0]   host_address,
   input  logic [WIDTH-1:0]           host_data_in,
   output logic [WIDTH-1:0]           host_data_out,
   output logic                       host_data_oe,
   output logic                       host_ack_n,
   output logic                       host_error,
   output logic [$clog2(COUNT)-1:0]   reg_address,
   output logic [WIDTH-1:0]           reg_data,
   output logic                       reg_wr_strobe,
   output logic                       reg_rd_strobe,
   input  logic [COUNT*WIDTH-1:0]     rd_data
);

   localparam int AW = $clog2(COUNT);

   typedef enum logic [2:0] {
      S_RELEASE = 3'd0,
      S_IDLE    = 3'd1,
      S_WRITE   = 3'd2,
      S_READ    = 3'd3,
      S_ACK     = 3'd4
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------
   // Strobe synchronisers (reset to the inactive level)
   // ------------------------------------------------------------------
   logic cs_meta_q, wr_meta_q, rd_meta_q;
   logic cs_s_q,    wr_s_q,    rd_s_q;

   // Marks when the second synchroniser stage holds a genuine pin sample
   // rather than its reset value. Without it, RELEASE would see the reset
   // value 1 as "cs released" and a cycle left pending across reset would
   // be executed as soon as the pipeline filled.
   logic [1:0] sync_fill_q;
   logic       sync_valid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cs_meta_q   <= 1'b1;
         wr_meta_q   <= 1'b1;
         rd_meta_q   <= 1'b1;
         cs_s_q      <= 1'b1;
         wr_s_q      <= 1'b1;
         rd_s_q      <= 1'b1;
         sync_fill_q <= 2'b00;
      end else begin
         cs_meta_q   <= host_cs_n;
         wr_meta_q   <= host_wr_n;
         rd_meta_q   <= host_rd_n;
         cs_s_q      <= cs_meta_q;
         wr_s_q      <= wr_meta_q;
         rd_s_q      <= rd_meta_q;
         sync_fill_q <= {sync_fill_q[0], 1'b1};
      end
   end

   assign sync_valid = sync_fill_q[1];

   // ------------------------------------------------------------------
   // Read-data word select
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] rd_words [COUNT];

   for (genvar gi = 0; gi < COUNT; gi++) begin : g_unpack
      assign rd_words[gi] = rd_data[gi*WIDTH +: WIDTH];
   end

   // ------------------------------------------------------------------
   // Registered datapath / outputs
   // ------------------------------------------------------------------
   logic [AW-1:0]    addr_q,  addr_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [WIDTH-1:0] dout_q,  dout_d;
   logic             oe_q,    oe_d;
   logic             err_q,   err_d;
   logic             ack_n_q, ack_n_d;
   logic             wr_stb_q, wr_stb_d;
   logic             rd_stb_q, rd_stb_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_RELEASE;
         addr_q   <= '0;
         data_q   <= '0;
         dout_q   <= '0;
         oe_q     <= 1'b0;
         err_q    <= 1'b0;
         ack_n_q  <= 1'b1;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         err_q    <= err_d;
         ack_n_q  <= ack_n_d;
         wr_stb_q <= wr_stb_d;
         rd_stb_q <= rd_stb_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dout_d  = dout_q;
      oe_d    = oe_q;
      err_d   = err_q;

      case (state_q)
         S_RELEASE: begin
            if (sync_valid && cs_s_q) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!cs_s_q) begin
               if (!wr_s_q && !rd_s_q) begin
                  // Both strobes low is illegal: flag it, drop the cycle
                  // and wait for the host to release chip select.
                  err_d   = 1'b1;
                  state_d = S_RELEASE;
               end else if (!wr_s_q) begin
                  addr_d  = host_address;
                  data_d  = host_data_in;
                  state_d = S_WRITE;
               end else if (!rd_s_q) begin
                  addr_d  = host_address;
                  dout_d  = rd_words[host_address];
                  oe_d    = 1'b1;
                  state_d = S_READ;
               end
            end
         end
         S_WRITE, S_READ: begin
            // The strobe has been issued; always acknowledge at least one
            // cycle even if the host already aborted.
            state_d = S_ACK;
         end
         S_ACK: begin
            if (cs_s_q) begin
               oe_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_RELEASE;
         end
      endcase

      // Strobes and ack are registered copies of the next-state decode so
      // they leave flops directly and cannot glitch.
      wr_stb_d = (state_d == S_WRITE);
      rd_stb_d = (state_d == S_READ);
      ack_n_d  = (state_d != S_ACK);
   end

   assign host_data_out = dout_q;
   assign host_data_oe  = oe_q;
   assign host_ack_n    = ack_n_q;
   assign host_error    = err_q;
   assign reg_address   = addr_q;
   assign reg_data      = data_q;
   assign reg_wr_strobe = wr_stb_q;
   assign reg_rd_strobe = rd_stb_q;

endmodule
`default_nettype wire
